// File: rtl/mvau_weight_loader.sv
// Scatters a stream of SIMD*TW-bit weight words over the PE weight memories (word k -> PE k mod PE, addr k div PE).
// Optional WLOAD_CHKSUM_EN adds load_chksum, the XOR of every word accepted during the current load.
//
//  state | meaning
//  IDLE  | waiting for load_start, stream not accepted
//  LOAD  | accepting words, one write per accepted beat
//  DONE  | one cycle: final write visible, load_done pulses
module mvau_weight_loader #(
    parameter int PE           = 2,
    parameter int SIMD         = 2,
    parameter int TW           = 4,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start,
    input  logic [SIMD*TW-1:0]      in_wgt,
    input  logic                    in_wgt_v,
    output logic                    in_wgt_rdy,
    output logic [PE-1:0]           wmem_we,
    output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
    output logic [SIMD*TW-1:0]      wmem_wdata,
    output logic                    load_busy,
`ifdef WLOAD_CHKSUM_EN
    output logic [SIMD*TW-1:0]      load_chksum,
`endif
    output logic                    load_done
);

    localparam int PE_BW = (PE > 1) ? $clog2(PE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [PE_BW-1:0]        pe_cnt;
    logic [WMEM_ADDR_BW-1:0] addr_cnt;
    logic [PE-1:0]           we_onehot;
    logic                    accept;
    logic                    last_pe;
    logic                    last_addr;
    logic                    last_beat;

    assign accept    = in_wgt_v & in_wgt_rdy;
    assign last_pe   = (pe_cnt == PE_BW'(PE - 1));
    assign last_addr = (addr_cnt == WMEM_ADDR_BW'(WMEM_DEPTH - 1));
    assign last_beat = accept & last_pe & last_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_wgt_rdy = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_wgt_rdy = 1'b1;
                load_busy  = 1'b1;
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // With PE=1 the compare against PE-1 always matches, so pe_cnt stays 0 and addr_cnt steps every beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_cnt   <= '0;
            addr_cnt <= '0;
        end else if (accept) begin
            if (last_pe) begin
                pe_cnt   <= '0;
                addr_cnt <= last_addr ? '0 : addr_cnt + 1'b1;
            end else begin
                pe_cnt <= pe_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        we_onehot = '0;
        for (int p = 0; p < PE; p++) begin
            we_onehot[p] = (pe_cnt == PE_BW'(p));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wmem_we    <= '0;
            wmem_waddr <= '0;
            wmem_wdata <= '0;
        end else begin
            wmem_we <= accept ? we_onehot : '0;
            if (accept) begin
                wmem_waddr <= addr_cnt;
                wmem_wdata <= in_wgt;
            end
        end
    end

`ifdef WLOAD_CHKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_chksum <= '0;
        end else if (state == IDLE && load_start) begin
            load_chksum <= '0;
        end else if (accept) begin
            load_chksum <= load_chksum ^ in_wgt;
        end
    end
`endif

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Bench for mvau_weight_loader: directed and random loads checked cycle by cycle against a load-level model.
// Build with WLOAD_CHKSUM_EN defined to also check load_chksum.
module tb_mvau_weight_loader;

    localparam int PE    = 2;
    localparam int SIMD  = 2;
    localparam int TW    = 4;
    localparam int DEPTH = 4;
    localparam int ABW   = 2;
    localparam int DW    = SIMD * TW;
    localparam int NW    = PE * DEPTH;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           load_start = 1'b0;
    logic [DW-1:0]  in_wgt = '0;
    logic           in_wgt_v = 1'b0;
    logic           in_wgt_rdy;
    logic [PE-1:0]  wmem_we;
    logic [ABW-1:0] wmem_waddr;
    logic [DW-1:0]  wmem_wdata;
    logic           load_busy;
    logic           load_done;
`ifdef WLOAD_CHKSUM_EN
    logic [DW-1:0]  load_chksum;
`endif

    mvau_weight_loader #(
        .PE(PE), .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .in_wgt     (in_wgt),
        .in_wgt_v   (in_wgt_v),
        .in_wgt_rdy (in_wgt_rdy),
        .wmem_we    (wmem_we),
        .wmem_waddr (wmem_waddr),
        .wmem_wdata (wmem_wdata),
        .load_busy  (load_busy),
`ifdef WLOAD_CHKSUM_EN
        .load_chksum(load_chksum),
`endif
        .load_done  (load_done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Load-level model: phase 0 idle, 1 loading, 2 completion cycle; m_k = words accepted this load.
    int             m_phase = 0;
    int             m_k = 0;
    logic [PE-1:0]  e_we = '0;
    logic [ABW-1:0] e_addr = '0;
    logic [DW-1:0]  e_data = '0;
    logic           e_done = 1'b0;
    logic [DW-1:0]  e_chk = '0;

    function automatic logic [14:0] obs_vec();
        return {in_wgt_rdy, load_busy, load_done, wmem_we, wmem_waddr, wmem_wdata};
    endfunction

    function automatic logic [14:0] exp_vec();
        logic busy;
        busy = (m_phase == 1);
        return {busy, busy, e_done, e_we, e_addr, e_data};
    endfunction

    function automatic logic [DW-1:0] chk_obs();
`ifdef WLOAD_CHKSUM_EN
        return load_chksum;
`else
        return e_chk;
`endif
    endfunction

    task automatic model_reset();
        m_phase = 0; m_k = 0;
        e_we = '0; e_addr = '0; e_data = '0; e_done = 1'b0; e_chk = '0;
    endtask

    // Drives one cycle's inputs at a falling edge, advances the model, returns at the next falling edge.
    task automatic drive_cycle(input logic start, input logic v, input logic [DW-1:0] d);
        load_start = start;
        in_wgt_v   = v;
        in_wgt     = d;
        e_we   = '0;
        e_done = 1'b0;
        case (m_phase)
            0: if (start) begin
                m_phase = 1;
                e_chk   = '0;
            end
            1: if (v) begin
                e_we   = PE'(1) << (m_k % PE);
                e_addr = ABW'(m_k / PE);
                e_data = d;
                e_chk  = e_chk ^ d;
                m_k++;
                if (m_k == NW) begin
                    m_phase = 2;
                    m_k     = 0;
                    e_done  = 1'b1;
                end
            end
            default: m_phase = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic check_outputs(input string name);
        total++;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL %s t=%0t got rdy/busy/done/we/addr/data=%b expected %b", name, $time, obs_vec(), exp_vec());
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (obs_vec() !== 15'd0) $display("FAIL reset got %b expected 0", obs_vec());
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_continuous();
        drive_cycle(1'b1, 1'b0, '0);
        check_outputs("cont_start");
        for (int i = 0; i < NW; i++) begin
            drive_cycle(1'b0, 1'b1, DW'(8'h10 + i));
            check_outputs("cont_word");
        end
        drive_cycle(1'b0, 1'b0, '0);
        check_outputs("cont_idle");
    endtask

    task automatic test_bubbles();
        drive_cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 2 * NW; i++) begin
            drive_cycle(1'b0, (i % 2) == 0, DW'(8'h10 + i / 2));
            if ((i % 2) == 1) begin
                total++;
                if (wmem_we !== '0) $display("FAIL bubble_we got %b expected 0", wmem_we);
                else passed++;
            end
            check_outputs("bubble_word");
        end
        drive_cycle(1'b0, 1'b0, '0);
        check_outputs("bubble_end");
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b1, DW'($urandom));
            total++;
            if (in_wgt_rdy !== 1'b0 || wmem_we !== '0)
                $display("FAIL idle_valid got rdy=%b we=%b expected rdy=0 we=0", in_wgt_rdy, wmem_we);
            else passed++;
        end
    endtask

    task automatic test_restart_ignored();
        drive_cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < NW; i++) begin
            drive_cycle(i == 3, 1'b1, DW'($urandom));
            check_outputs("restart_word");
        end
        // start during the completion cycle must not open a new load
        drive_cycle(1'b1, 1'b1, DW'($urandom));
        check_outputs("start_in_done");
        drive_cycle(1'b0, 1'b1, DW'($urandom));
        check_outputs("after_done");
    endtask

    task automatic test_reset_midload();
        drive_cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b1, DW'($urandom));
            check_outputs("pre_reset_word");
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs_vec() !== 15'd0) $display("FAIL midload_reset got %b expected 0", obs_vec());
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, 1'b0, '0);
        drive_cycle(1'b0, 1'b1, 8'hA5);
        total++;
        if (wmem_we !== 2'b01 || wmem_waddr !== 2'd0 || wmem_wdata !== 8'hA5)
            $display("FAIL reload_first got we=%b addr=%0d data=%h expected 01/0/a5", wmem_we, wmem_waddr, wmem_wdata);
        else passed++;
        for (int i = 1; i < NW; i++) begin
            drive_cycle(1'b0, 1'b1, DW'($urandom));
            check_outputs("reload_word");
        end
        drive_cycle(1'b0, 1'b0, '0);
        check_outputs("reload_end");
    endtask

    task automatic test_random();
        for (int l = 0; l < 3; l++) begin
            drive_cycle(1'b1, 1'b0, '0);
            for (int i = 0; i < 80 && m_phase != 0; i++) begin
                drive_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, DW'($urandom));
                check_outputs("random");
            end
            total++;
            if (m_phase != 0) $display("FAIL random_timeout got phase=%0d expected 0", m_phase);
            else passed++;
        end
    endtask

    task automatic test_chksum();
        logic [DW-1:0] w;
        drive_cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < NW; i++) begin
            w = DW'(1) << i;
            drive_cycle(1'b0, 1'b1, w);
            check_outputs("chk_word");
        end
`ifdef WLOAD_CHKSUM_EN
        total++;
        if (load_done !== 1'b1 || load_chksum !== 8'hFF)
            $display("FAIL chksum got done=%b chk=%h expected 1/ff", load_done, load_chksum);
        else passed++;
        drive_cycle(1'b0, 1'b1, 8'h3C);
        total++;
        if (chk_obs() !== e_chk) $display("FAIL chksum_hold got %h expected %h", chk_obs(), e_chk);
        else passed++;
        drive_cycle(1'b1, 1'b0, '0);
        total++;
        if (chk_obs() !== 8'h00) $display("FAIL chksum_clear got %h expected 00", chk_obs());
        else passed++;
        drive_cycle(1'b0, 1'b1, 8'h5A);
        drive_cycle(1'b0, 1'b1, 8'h0F);
        total++;
        if (chk_obs() !== 8'h55) $display("FAIL chksum_accum got %h expected 55", chk_obs());
        else passed++;
        for (int i = 2; i < NW; i++) drive_cycle(1'b0, 1'b1, 8'h00);
        drive_cycle(1'b0, 1'b0, '0);
`else
        drive_cycle(1'b0, 1'b0, '0);
`endif
        check_outputs("chk_end");
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_bubbles();
        test_idle_valid();
        test_restart_ignored();
        test_reset_midload();
        test_random();
        test_chksum();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
